// File: rtl/regfile_mp_if.sv
// Register file access bundle: decode reads, issue marking, writeback and soft clear.
// master = pipeline side driving requests, slave = register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] i_raddr;
    logic [NREAD*DATA_W-1:0] o_rdata;
    logic [NREAD-1:0]        o_busy;
    logic                    i_we;
    logic [ADDR_W-1:0]       i_waddr;
    logic [DATA_W-1:0]       i_wdata;
    logic                    i_issue;
    logic [ADDR_W-1:0]       i_issue_addr;
    logic                    i_clr;
    logic                    o_ready;

    modport master (
        output i_raddr, i_we, i_waddr, i_wdata, i_issue, i_issue_addr, i_clr,
        input  o_rdata, o_busy, o_ready
    );

    modport slave (
        input  i_raddr, i_we, i_waddr, i_wdata, i_issue, i_issue_addr, i_clr,
        output o_rdata, o_busy, o_ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard and sequential soft clear (optional REGFILE_BYPASS_EN forwarding).
// Latency: reads combinational (0 cycles); writes/issues take effect at the next i_clk edge; clear takes DEPTH-1 cycles.
// Backpressure: o_ready low during clear; writes, issues and clear requests presented then are dropped.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;

    logic ready;
    logic we_ok;
    logic issue_ok;

    assign ready    = (state == ST_IDLE);
    assign we_ok    = bus.i_we & ready & (bus.i_waddr != '0);
    assign issue_ok = bus.i_issue & ready & (bus.i_issue_addr != '0);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
            state  <= ST_IDLE;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (we_ok) begin
                        regs[bus.i_waddr]   <= bus.i_wdata;
                        busy_q[bus.i_waddr] <= 1'b0;
                    end
                    // Issue is ordered after the write so the newer producer keeps busy set.
                    if (issue_ok) begin
                        busy_q[bus.i_issue_addr] <= 1'b1;
                    end
                    if (bus.i_clr) begin
                        busy_q <= '0;
                        state  <= ST_CLEAR;
                        idx    <= ADDR_W'(1);
                    end
                end
                ST_CLEAR: begin
                    regs[idx] <= '0;
                    if (idx == LAST_IDX) begin
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD-1:0]        rbusy;
    logic [ADDR_W-1:0]       ra;

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = bus.i_raddr[k*ADDR_W +: ADDR_W];
            if (ra != '0) begin
                rdata[k*DATA_W +: DATA_W] = regs[ra];
                rbusy[k]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (we_ok && (bus.i_waddr == ra)) begin
                    rdata[k*DATA_W +: DATA_W] = bus.i_wdata;
                    rbusy[k]                  = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.o_rdata = rdata;
    assign bus.o_busy  = rbusy;
    assign bus.o_ready = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 2 ** AW;

    logic i_clk;
    logic i_nrst;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .bus    (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]    busy;
        logic             ready;
    } exp_t;

    exp_t exp_q[$];

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    int            clr_pos;          // 0 = not clearing, else next register the clear will zero

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        clr_pos = 0;
    endtask

    // Apply the rules for one rising edge using the inputs presented in the cycle before it.
    task automatic model_edge();
        int wa, ia;
        wa = int'(bus.i_waddr);
        ia = int'(bus.i_issue_addr);
        if (clr_pos == 0) begin
            if (bus.i_we && wa != 0) begin
                m_mem[wa]  = bus.i_wdata;
                m_busy[wa] = 1'b0;
            end
            if (bus.i_issue && ia != 0) m_busy[ia] = 1'b1;
            if (bus.i_clr) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
                clr_pos = 1;
            end
        end else begin
            m_mem[clr_pos] = '0;
            clr_pos = (clr_pos == DEPTH - 1) ? 0 : clr_pos + 1;
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   a;
        e.rdata = '0;
        e.busy  = '0;
        e.ready = (clr_pos == 0);
        for (int k = 0; k < NR; k++) begin
            a = int'(bus.i_raddr[k*AW +: AW]);
            if (a != 0) begin
                e.rdata[k*DW +: DW] = m_mem[a];
                e.busy[k]           = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                if (bus.i_we && clr_pos == 0 && int'(bus.i_waddr) == a) begin
                    e.rdata[k*DW +: DW] = bus.i_wdata;
                    e.busy[k]           = 1'b0;
                end
`endif
            end
        end
        return e;
    endfunction

    task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                         input bit iss, input int ia, input bit clr,
                         input int r0, input int r1);
        bus.i_we         = we;
        bus.i_waddr      = wa[AW-1:0];
        bus.i_wdata      = wd;
        bus.i_issue      = iss;
        bus.i_issue_addr = ia[AW-1:0];
        bus.i_clr        = clr;
        bus.i_raddr      = {r1[AW-1:0], r0[AW-1:0]};
    endtask

    task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit iss, input int ia, input bit clr,
                        input int r0, input int r1);
        @(posedge i_clk);
        model_edge();
        #1;
        drive(we, wa, wd, iss, ia, clr, r0, r1);
        exp_q.push_back(predict());
    endtask

    task automatic check_reset_now(input string nm);
        chk({nm, "_rdata0"}, 64'(bus.o_rdata[0 +: DW]), 64'd0);
        chk({nm, "_rdata1"}, 64'(bus.o_rdata[DW +: DW]), 64'd0);
        chk({nm, "_busy"},   64'(bus.o_busy), 64'd0);
        chk({nm, "_ready"},  64'(bus.o_ready), 64'd1);
    endtask

    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdata0", 64'(bus.o_rdata[0 +: DW]),  64'(e.rdata[0 +: DW]));
            chk("rdata1", 64'(bus.o_rdata[DW +: DW]), 64'(e.rdata[DW +: DW]));
            chk("busy",   64'(bus.o_busy),  64'(e.busy));
            chk("ready",  64'(bus.o_ready), 64'(e.ready));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa, r0;
        model_reset();
        drive(0, 0, '0, 0, 0, 0, 5, 7);
        i_nrst = 1'b1;
        #1 i_nrst = 1'b0;
        #2 check_reset_now("reset");
        #9 i_nrst = 1'b1;

        // write/read and register 0
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0, 5, 0);
        step(1, 0, 32'h1234, 0, 0, 0, 0, 5);
        step(0, 0, '0, 0, 0, 0, 0, 5);

        // busy scoreboard
        step(0, 0, '0, 1, 7, 0, 7, 0);
        step(0, 0, '0, 0, 0, 0, 7, 7);
        step(1, 7, 32'h77, 0, 0, 0, 0, 7);
        step(0, 0, '0, 0, 0, 0, 7, 0);
        step(1, 7, 32'h78, 1, 7, 0, 7, 0);
        step(0, 0, '0, 1, 0, 0, 7, 0);
        step(0, 0, '0, 0, 0, 0, 7, 0);

        // write-to-read in the same cycle
        step(1, 3, 32'hA, 0, 0, 0, 0, 0);
        step(1, 3, 32'hB, 0, 0, 0, 0, 3);
        step(0, 0, '0, 0, 0, 0, 3, 3);

        // soft clear with full register file and dropped requests
        for (int i = 1; i < DEPTH; i++) step(1, i, $urandom | 32'h1, i[0], i, 0, i, DEPTH - i);
        step(1, 9, 32'h5555, 1, 4, 1, 9, 4);
        for (int i = 0; i < DEPTH; i++)
            step(1, $urandom_range(1, DEPTH - 1), $urandom, 1, $urandom_range(1, DEPTH - 1),
                 i[0], $urandom_range(0, DEPTH - 1), i);
        for (int i = 0; i < DEPTH / 2; i++) step(0, 0, '0, 0, 0, 0, 2 * i, 2 * i + 1);

        // reset abort in the middle of a clear
        for (int i = 1; i < 6; i++) step(1, i, 32'hC0DE0000 + i, 1, i + 8, 0, i, i + 8);
        step(0, 0, '0, 0, 0, 1, 1, 2);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 0, 0, 0, 3, 4);
        @(negedge i_clk);
        #2 i_nrst = 1'b0;
        model_reset();
        drive(0, 0, '0, 0, 0, 0, 1, 9);
        #1 check_reset_now("abort");
        @(negedge i_clk);
        #2 i_nrst = 1'b1;
        step(0, 0, '0, 0, 0, 0, 2, 10);
        step(0, 0, '0, 0, 0, 0, 5, 31);

        // random traffic concentrated on a few registers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            wa = $urandom % 8;
            r0 = ($urandom % 2 == 1) ? wa : int'($urandom % 8);
            step($urandom % 2, wa, $urandom, ($urandom % 3) == 0, $urandom % 8,
                 ($urandom % 60) == 0, r0, $urandom % DEPTH);
        end

        step(0, 0, '0, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
